// File: rtl/muldiv_sequencer_if.sv
// HI/LO multiply/divide request and result bundle shared by the core and the sequencer.
interface muldiv_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Core side: issues operations and MTHI/MTLO, reads HI/LO.
    modport master (
        output start, op, a, b, mthi, mtlo, wdata,
        input  busy, done, hi, lo
    );

    // Sequencer side.
    modport slave (
        input  start, op, a, b, mthi, mtlo, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle HI/LO multiply/divide sequencer: one radix-2 step per clock, fixed latency,
// owns the architectural HI/LO registers.
module muldiv_sequencer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEPS = WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    muldiv_sequencer_if.slave bus
);
    localparam int unsigned CntW = $clog2(STEPS + 1);

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e               state_q;
    logic                 is_div_q;
    logic                 sign_a_q;
    logic                 sign_b_q;
    logic [WIDTH-1:0]     opnd_q;    // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0]   acc_q;     // {hi_part, lo_part} or {rem, quot}
    logic [CntW-1:0]      cnt_q;
    logic                 busy_q;
    logic                 done_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;

    logic                 neg_a;
    logic                 neg_b;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       rem_sh;
    logic                 div_ok;
    logic [WIDTH-1:0]     div_diff;
    logic [WIDTH-1:0]     rem_new;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix;
    logic [WIDTH-1:0]     rem_fix;

    // Operand magnitudes and signs; 0x80000000 negates to itself and is used as unsigned.
    always_comb begin
        neg_a = bus.op[0] & bus.a[WIDTH-1];
        neg_b = bus.op[0] & bus.b[WIDTH-1];
        mag_a = neg_a ? -bus.a : bus.a;
        mag_b = neg_b ? -bus.b : bus.b;
    end

    // Single shift-add multiply step and single restoring divide step.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};

        rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
        div_ok   = rem_sh >= {1'b0, opnd_q};
        // When the trial succeeds the true difference fits in WIDTH bits.
        div_diff = rem_sh[WIDTH-1:0] - opnd_q;
        rem_new  = div_ok ? div_diff : rem_sh[WIDTH-1:0];
        div_next = {rem_new, acc_q[WIDTH-2:0], div_ok};
    end

    // Sign fix-up; sign flags are already zero for unsigned ops.
    always_comb begin
        prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
        quot_fix = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    // Control FSM with registered busy/done and the HI/LO registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            is_div_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        // start takes priority; a simultaneous MTHI/MTLO is dropped
                        is_div_q <= bus.op[1];
                        sign_a_q <= neg_a;
                        sign_b_q <= neg_b;
                        opnd_q   <= bus.op[1] ? mag_b : mag_a;
                        acc_q    <= {{WIDTH{1'b0}}, (bus.op[1] ? mag_a : mag_b)};
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= StRun;
                    end else begin
                        if (bus.mthi) hi_q <= bus.wdata;
                        if (bus.mtlo) lo_q <= bus.wdata;
                    end
                end
                StRun: begin
                    acc_q <= is_div_q ? div_next : mul_next;
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == CntW'(STEPS - 1)) state_q <= StFix;
                end
                StFix: begin
                    if (is_div_q) begin
                        hi_q <= rem_fix;
                        lo_q <= quot_fix;
                    end else begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed corner cases, randomized ops against an
// arithmetic reference model, MTHI/MTLO handling, ignored inputs, back-to-back and reset.
module tb_muldiv_sequencer;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    muldiv_sequencer_if #(.WIDTH(32)) bus ();

    muldiv_sequencer #(.WIDTH(32), .STEPS(32)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference result {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint unsigned pu;
        longint          ps;
        int              sa, sb, q, r;
        case (op)
            2'b00: begin
                pu = {32'd0, a} * {32'd0, b};
                return pu;
            end
            2'b01: begin
                ps = longint'($signed(a)) * longint'($signed(b));
                return ps;
            end
            2'b10: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: begin
                if (b == 0) return {a, (a[31] ? 32'd1 : 32'hFFFF_FFFF)};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                sa = $signed(a);
                sb = $signed(b);
                q  = sa / sb;
                r  = sa % sb;
                return {r, q};
            end
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return $urandom_range(0, 255);
            default: return $urandom;
        endcase
    endfunction

    // Present an op for one edge; returns #1 after the accepting edge.
    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        check_eq("busy_after_start", 64'(bus.busy), 64'd1);
    endtask

    // Count remaining busy edges, then check done and HI/LO in the done cycle.
    task automatic wait_done(input string tag, input int exp_lat, input logic [63:0] exp);
        int cyc = 0;
        while (bus.busy === 1'b1 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_eq({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
        check_eq({tag, "_done"}, 64'(bus.done), 64'd1);
        check_eq({tag, "_hilo"}, {bus.hi, bus.lo}, exp);
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp);
        launch(op, a, b);
        wait_done(tag, 33, exp);
        @(posedge clk);
        #1;
        check_eq({tag, "_done_low"}, 64'(bus.done), 64'd0);
    endtask

    logic [1:0]  d_op  [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b11};
    logic [31:0] d_a   [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000, 32'd100,
                               32'hFFFF_FFF9, 32'd7, 32'd5, 32'h8000_0000};
    logic [31:0] d_b   [8] = '{32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'd7,
                               32'd2, 32'hFFFF_FFFE, 32'd0, 32'hFFFF_FFFF};
    logic [63:0] d_exp [8] = '{64'hFFFF_FFFE_0000_0001, 64'hFFFF_FFFF_FFFF_FFEB,
                               64'h4000_0000_0000_0000, 64'h0000_0002_0000_000E,
                               64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0001_FFFF_FFFD,
                               64'h0000_0005_FFFF_FFFF, 64'h0000_0000_8000_0000};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation timeout");
    end

    initial begin
        logic [1:0]  r_op;
        logic [31:0] r_a, r_b, hi_prev, lo_prev;
        int          pulses;

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        bus.wdata = '0;
        #3;
        check_eq("reset_busy", 64'(bus.busy), 64'd0);
        check_eq("reset_done", 64'(bus.done), 64'd0);
        check_eq("reset_hilo", {bus.hi, bus.lo}, 64'd0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("directed%0d", i), d_op[i], d_a[i], d_b[i], d_exp[i]);
        end

        for (int i = 0; i < 40; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = pick_operand();
            r_b  = pick_operand();
            run_op($sformatf("rand%0d_op%0d", i, r_op), r_op, r_a, r_b, ref_model(r_op, r_a, r_b));
        end

        // MTLO alone, then MTHI+MTLO together, in IDLE.
        hi_prev   = bus.hi;
        bus.wdata = 32'h0000_1234;
        bus.mtlo  = 1'b1;
        @(posedge clk);
        #1;
        bus.mtlo = 1'b0;
        check_eq("mtlo_write", {bus.hi, bus.lo}, {hi_prev, 32'h0000_1234});
        bus.wdata = 32'hCAFE_F00D;
        bus.mthi  = 1'b1;
        bus.mtlo  = 1'b1;
        @(posedge clk);
        #1;
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        check_eq("mthi_mtlo_write", {bus.hi, bus.lo}, {32'hCAFE_F00D, 32'hCAFE_F00D});

        // start wins over a simultaneous MTHI.
        bus.wdata = 32'hDEAD_BEEF;
        bus.mthi  = 1'b1;
        launch(2'b00, 32'd3, 32'd5);
        wait_done("start_mthi", 33, 64'd15);

        // start/MTHI/MTLO during RUN are ignored and HI/LO hold.
        @(posedge clk);
        #1;
        hi_prev = bus.hi;
        lo_prev = bus.lo;
        launch(2'b10, 32'd1000, 32'd7);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        bus.op    = 2'b00;
        bus.a     = 32'd1;
        bus.b     = 32'd1;
        bus.wdata = 32'h5555_5555;
        bus.start = 1'b1;
        bus.mthi  = 1'b1;
        bus.mtlo  = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        check_eq("run_ignore_hold", {bus.hi, bus.lo}, {hi_prev, lo_prev});
        check_eq("run_ignore_busy", 64'(bus.busy), 64'd1);
        wait_done("run_ignore", 27, ref_model(2'b10, 32'd1000, 32'd7));

        // Back-to-back: start in the done cycle is accepted.
        @(posedge clk);
        #1;
        launch(2'b00, 32'd6, 32'd7);
        wait_done("b2b_first", 33, 64'd42);
        launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("b2b_second", 33, 64'd1);

        // Asynchronous reset during RUN step 10.
        @(posedge clk);
        #1;
        launch(2'b00, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        #3;
        reset = 1'b1;
        #1;
        check_eq("async_reset_busy", 64'(bus.busy), 64'd0);
        check_eq("async_reset_hilo", {bus.hi, bus.lo}, 64'd0);
        check_eq("async_reset_done", 64'(bus.done), 64'd0);
        @(posedge clk);
        #3;
        reset  = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) pulses++;
        end
        check_eq("post_reset_quiet", 64'(pulses), 64'd0);
        run_op("post_reset_multu", 2'b00, 32'd6, 32'd7, 64'd42);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
